// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole game engine.
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPAWN = 2'd1,
    UP    = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MODE_SEQ  = 0;
  localparam int MODE_RAND = 1;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_POLY = 16'hB400;

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR; only the low OUT_W bits are exported.
module mole_lfsr
  import mole_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [OUT_W-1:0] bits
);

  logic [15:0] lfsr;

  // Advance one step every cycle, shifting right and folding in the taps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= SEED;
    else          lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0000);
  end

  assign bits = lfsr[OUT_W-1:0];

endmodule

// File: rtl/mole_game.sv
// Whack-a-mole engine: one mole at a time, hit/miss scoring, timeout,
// wrong-switch penalty, sequential or pseudo-random hole order.
module mole_game
  import mole_pkg::*;
#(
  parameter int          N_HOLES        = 16,
  parameter int          ROUNDS         = 32,
  parameter int          SCORE_W        = 6,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
  parameter int          MODE           = 0,
  parameter int          PENALTY        = 1,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [N_HOLES-1:0] sw,
  output logic [N_HOLES-1:0] LED,
  output logic [SCORE_W-1:0] score_count,
  output logic [SCORE_W-1:0] miss_count,
  output logic               busy,
  output logic               game_over
);

  localparam int               IDX_W    = $clog2(N_HOLES);
  localparam int               RND_W    = $clog2(ROUNDS + 1);
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N_HOLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_HOLES - 1);

  state_t             state, state_nxt;
  logic [N_HOLES-1:0] sw_q, tog, mask;
  logic [IDX_W-1:0]   idx, idx_nxt, lfsr_bits, red;
  logic [IDX_W:0]     raw;
  logic [RND_W-1:0]   round_cnt, round_inc;
  logic [31:0]        timer;
  logic               hit, wrong, tmo, ev, last;

  mole_lfsr #(.SEED(LFSR_SEED), .OUT_W(IDX_W)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .bits    (lfsr_bits)
  );

  // Switch history for edge detection; tracks sw in every state.
  always_ff @(posedge clk) sw_q <= sw;

  assign tog       = sw ^ sw_q;
  assign mask      = N_HOLES'(1) << idx;
  assign hit       = |(tog & mask);
  assign wrong     = (PENALTY != 0) && |(tog & ~mask);
  assign tmo       = (timer == 32'd0);
  assign ev        = hit || wrong || tmo;
  assign round_inc = round_cnt + RND_W'(1);
  assign last      = (round_inc == RND_W'(ROUNDS));

  // Next hole: sequential wrap, or reduced LFSR bits nudged off the previous hole.
  always_comb begin
    raw     = {1'b0, lfsr_bits};
    red     = (raw >= N_EXT) ? IDX_W'(raw - N_EXT) : lfsr_bits;
    idx_nxt = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    if (MODE == MODE_RAND) begin
      if (red == idx) idx_nxt = (red == LAST_IDX) ? '0 : red + IDX_W'(1);
      else            idx_nxt = red;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SPAWN;
      SPAWN:   state_nxt = UP;
      UP:      if (ev) state_nxt = last ? DONE : SPAWN;
      DONE:    if (start) state_nxt = SPAWN;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded status outputs.
  always_comb begin
    busy      = (state == SPAWN) || (state == UP);
    game_over = (state == DONE);
  end

  // Datapath: mole position, timer, scores and round count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      LED         <= '0;
      score_count <= '0;
      miss_count  <= '0;
      round_cnt   <= '0;
      timer       <= '0;
      idx         <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          LED <= '0;
          if (start) begin
            score_count <= '0;
            miss_count  <= '0;
            round_cnt   <= '0;
            // parking on the last hole makes the sequential order start at 0
            idx         <= LAST_IDX;
          end
        end
        SPAWN: begin
          idx   <= idx_nxt;
          LED   <= N_HOLES'(1) << idx_nxt;
          timer <= TIMEOUT_CYCLES - 32'd1;
        end
        UP: begin
          if (hit) begin
            if (score_count != '1) score_count <= score_count + SCORE_W'(1);
          end else if (wrong || tmo) begin
            if (miss_count != '1) miss_count <= miss_count + SCORE_W'(1);
          end else begin
            timer <= timer - 32'd1;
          end
          if (ev) begin
            LED       <= '0;
            round_cnt <= round_inc;
          end
        end
        default: LED <= '0;
      endcase
    end
  end

endmodule

// File: doc/mole_game.md
# mole_game

Parametrised whack-a-mole game engine: lights one "mole" LED at a time, waits for the player to toggle the matching switch, and keeps hit and miss scores. It replaces the fixed 16-hole, fixed-sequence game FSM. It adds configurable hole count and round count, a per-mole timeout, wrong-switch penalties, and a sequential or pseudo-random mole order. It sits between the debounced switch bank and the LED / score-display logic.

## Interface
- `N_HOLES`, 16: number of holes, i.e. LEDs and switches; legal range 2..16.
- `ROUNDS`, 32: moles per game.
- `SCORE_W`, 6: width of the score and miss counters.
- `TIMEOUT_CYCLES`, 50_000_000: cycles a mole stays up; legal range ≥1, fits 32 bits.
- `MODE`, 0: 0 = sequential order (0,1,…,N_HOLES-1, wrapping); 1 = pseudo-random order.
- `PENALTY`, 1: 1 = toggling a wrong switch while a mole is up counts as a miss; 0 = ignored.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk`  in  1: clock. One clock; everything is synchronous to `clk`.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: one-cycle pulse; starts a game from IDLE or DONE; ignored otherwise.
- `sw`  in  N_HOLES: switch levels, already synchronised and debounced upstream.
- `LED`  out  N_HOLES: registered; one-hot mole position, otherwise 0.
- `score_count`  out  SCORE_W: registered hit count.
- `miss_count`  out  SCORE_W: registered miss count.
- `busy`  out  1: high in SPAWN and UP.
- `game_over`  out  1: high in DONE.

## Operation
- Reset state: state IDLE; `LED`, `score_count`, `miss_count`, `busy` and `game_over` all 0; `sw_q` = `sw` at the first clock; LFSR = `LFSR_SEED`; round counter 0.
- Toggle detection: `sw_q` registers `sw` every cycle. `tog = sw ^ sw_q`. Either edge direction counts as a toggle.
- FSM states and transitions:
  - IDLE: on `start`, clear both scores and the round counter, then go to SPAWN.
  - SPAWN (1 cycle): compute the hole index, load the timer with `TIMEOUT_CYCLES-1`, set `LED` one-hot at the index, go to UP.
  - UP, checked in priority order:
    1. `tog[idx]` → hit: score +1.
    2. else `PENALTY` and any other `tog` bit set → miss +1.
    3. else timer == 0 → miss +1.
    4. else timer decrements.
  - On any UP event: clear `LED`, increment the round counter, go to DONE if rounds == `ROUNDS`, else SPAWN.
  - DONE: `LED` = 0, `game_over` = 1. `start` clears the scores and goes to SPAWN.
- Index rules:
  - MODE 0: first mole at index 0, then previous index +1, wrapping at N_HOLES.
  - MODE 1: LFSR is 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, free-running every cycle.
    - Raw value = `lfsr[IDX_W-1:0]`, where `IDX_W = clog2(N_HOLES)`.
    - If raw ≥ N_HOLES, subtract N_HOLES.
    - If the result equals the previous index, add 1 mod N_HOLES. A hole is never repeated back-to-back.
- Arithmetic: score and miss counters saturate at 2^SCORE_W-1. The round counter is clog2(ROUNDS+1) bits.
- Toggles seen in IDLE, SPAWN or DONE are ignored; `sw_q` still tracks `sw`.
- Simultaneous events:
  - Target toggle with a wrong toggle in the same cycle → hit only.
  - Target toggle with timer == 0 → hit only.
- `start` during SPAWN or UP is ignored.
- `reset_n` low at any time forces the reset state immediately, with no clock needed; the game in progress is lost.

## Timing
- `start` sampled at edge k → SPAWN during cycle k+1 → `LED` valid and UP state from edge k+2.
- Hit latency: a toggle visible on `sw` at edge t → score updated and `LED` = 0 at edge t+1.
- Unanswered mole: UP lasts exactly `TIMEOUT_CYCLES` cycles, then a miss is recorded.
- Per-mole period without input = `TIMEOUT_CYCLES`+1 cycles, including the SPAWN cycle.
- `game_over` rises on the edge that records the final round's event.

## Structure
- Package `mole_pkg`: FSM state enum (IDLE, SPAWN, UP, DONE), mode constants `MODE_SEQ` and `MODE_RAND`, LFSR polynomial constant `LFSR_POLY` = 16'hB400.
- One sub-module: `mole_lfsr`, the 16-bit Galois LFSR with seed parameter and advance-every-cycle output. The index reduction logic stays in `mole_game`.

## Test plan
1. Reset: hold `reset_n` low → all outputs 0. Release; hold 5 idle cycles with no `start` → outputs stay 0, state IDLE.
2. N=16, ROUNDS=4, MODE 0, TIMEOUT=8: pulse `start`, toggle `sw[0]`..`sw[3]` as each LED appears → `LED` sequence 0x0001, 0x0002, 0x0004, 0x0008; final score=4, miss=0, `game_over`=1, `LED`=0.
3. Same config, no switch activity → each mole is up exactly 8 cycles; `game_over` rises 36 cycles after SPAWN is entered; miss=4, score=0. A second `start` pulse clears both counters.
4. PENALTY=1: toggle `sw[5]` while mole 0 is up → miss=1, next mole at index 1. Repeat with PENALTY=0 → ignored, mole 0 stays up until timeout.
5. Priority: toggle `sw[0]` and `sw[3]` in the same cycle → score +1, miss unchanged. Toggle the target in the timer == 0 cycle → hit, not miss.
6. MODE 1, N=10, ROUNDS=1000, SCORE_W=3, all hits → every index <10, no back-to-back repeat, score saturates at 7. Assert `reset_n` mid-UP → outputs 0 asynchronously.
